// File: rtl/mux_scan_nto1_if.sv
// Request/beat bundle for mux_scan_nto1: request side (data, select, mode, abort)
// and the registered output beat stream with its backpressure.
interface mux_scan_nto1_if #(
  parameter int N = 32,
  parameter int W = 1
) ();
  localparam int SW = $clog2(N);

  logic [N*W-1:0] data_i;
  logic [SW-1:0]  sel_i;
  logic           mode_i;
  logic           valid_i;
  logic           ready_o;
  logic           abort_i;
  logic [W-1:0]   out_o;
  logic [SW-1:0]  ch_o;
  logic           valid_o;
  logic           ready_i;
  logic           last_o;
  logic           busy_o;

  modport slave (
    input  data_i, sel_i, mode_i, valid_i, abort_i, ready_i,
    output ready_o, out_o, ch_o, valid_o, last_o, busy_o
  );

  modport master (
    output data_i, sel_i, mode_i, valid_i, abort_i, ready_i,
    input  ready_o, out_o, ch_o, valid_o, last_o, busy_o
  );
endinterface

// File: rtl/mux_scan_nto1.sv
// N-to-1 lane multiplexer: a direct request emits one selected lane, a scan request
// emits all N lanes starting at the given index, with a single-entry output slot.
module mux_scan_nto1 #(
  parameter int N = 32,
  parameter int W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mux_scan_nto1_if.slave   bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_CNT = SW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  lanes_s [N];
  logic          slot_free_s;

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lanes_s[k] = bus.data_i[k*W +: W];
  end

  assign slot_free_s = !valid_q || bus.ready_i;

  // Next-state and next-beat computation; the output slot only reloads when free.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i && slot_free_s) begin
          if (!bus.mode_i) begin
            out_d   = lanes_s[bus.sel_i];
            ch_d    = bus.sel_i;
            last_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            idx_d   = bus.sel_i;
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // Abort wins over emitting a beat; any pending beat drains normally.
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end else if (slot_free_s) begin
          out_d   = lanes_s[idx_q];
          ch_d    = idx_q;
          valid_d = 1'b1;
          last_d  = (cnt_q == LAST_CNT);
          idx_d   = idx_q + SW'(1);
          cnt_d   = cnt_q + SW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready_o = (state_q == ST_IDLE) && slot_free_s;
  assign bus.busy_o  = (state_q == ST_SCAN);
  assign bus.out_o   = out_q;
  assign bus.ch_o    = ch_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: direct mode on a 32x1 instance, scan, backpressure,
// abort, reset and held-request cases on an 8x4 instance.
module tb_mux_scan_nto1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_scan_nto1_if #(.N(32), .W(1)) bus32 ();
  mux_scan_nto1_if #(.N(8),  .W(4)) bus8 ();

  mux_scan_nto1 #(.N(32), .W(1)) u32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));
  mux_scan_nto1 #(.N(8),  .W(4)) u8  (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one beat of the 8x4 instance: output lane equals its channel index.
  task automatic chk_beat8(input string tag, input int ch, input logic last);
    chk({tag, " valid"}, 32'(bus8.valid_o), 32'd1);
    chk({tag, " out"},   32'(bus8.out_o),   32'(ch));
    chk({tag, " ch"},    32'(bus8.ch_o),    32'(ch));
    chk({tag, " last"},  32'(last),         32'(bus8.last_o));
  endtask

  task automatic start_scan8(input logic [2:0] sel);
    bus8.valid_i = 1'b1;
    bus8.mode_i  = 1'b1;
    bus8.sel_i   = sel;
    #1;
    chk("scan ready", 32'(bus8.ready_o), 32'd1);
    tick();
    bus8.valid_i = 1'b0;
    chk("scan accept busy",  32'(bus8.busy_o),  32'd1);
    chk("scan accept valid", 32'(bus8.valid_o), 32'd0);
  endtask

  initial begin
    bus32.data_i = 32'h0; bus32.sel_i = 5'd0; bus32.mode_i = 1'b0; bus32.valid_i = 1'b0;
    bus32.abort_i = 1'b0; bus32.ready_i = 1'b1;
    bus8.data_i = 32'h76543210; bus8.sel_i = 3'd0; bus8.mode_i = 1'b0; bus8.valid_i = 1'b0;
    bus8.abort_i = 1'b0; bus8.ready_i = 1'b1;

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst valid32", 32'(bus32.valid_o), 32'd0);
    chk("rst last32",  32'(bus32.last_o),  32'd0);
    chk("rst ready32", 32'(bus32.ready_o), 32'd1);
    chk("rst busy8",   32'(bus8.busy_o),   32'd0);
    chk("rst out8",    32'(bus8.out_o),    32'd0);
    chk("rst ch8",     32'(bus8.ch_o),     32'd0);

    // Direct mode, back-to-back requests
    bus32.valid_i = 1'b1; bus32.mode_i = 1'b0;
    bus32.data_i = 32'hA99999CC; bus32.sel_i = 5'd20;
    tick();
    chk("dir20 valid", 32'(bus32.valid_o), 32'd1);
    chk("dir20 out",   32'(bus32.out_o),   32'd1);
    chk("dir20 ch",    32'(bus32.ch_o),    32'd20);
    chk("dir20 last",  32'(bus32.last_o),  32'd1);
    bus32.data_i = 32'hFFFFFFFF; bus32.sel_i = 5'd28;
    tick();
    chk("dir28 out", 32'(bus32.out_o), 32'd1);
    chk("dir28 ch",  32'(bus32.ch_o),  32'd28);
    bus32.data_i = 32'h40E0030D; bus32.sel_i = 5'd3;
    tick();
    chk("dir3 out", 32'(bus32.out_o), 32'd1);
    bus32.sel_i = 5'd4;
    tick();
    chk("dir4 out", 32'(bus32.out_o), 32'd0);
    chk("dir4 ch",  32'(bus32.ch_o),  32'd4);
    bus32.valid_i = 1'b0;
    tick();
    chk("dir drain valid", 32'(bus32.valid_o), 32'd0);

    // Scan with wrap, with a direct request held throughout the scan
    start_scan8(3'd6);
    bus8.valid_i = 1'b1; bus8.mode_i = 1'b0; bus8.sel_i = 3'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_beat8("wrap beat", (6 + i) % 8, (i == 7));
      if (i < 7) begin
        chk("wrap held ready", 32'(bus8.ready_o), 32'd0);
        chk("wrap busy",       32'(bus8.busy_o),  32'd1);
      end
    end
    bus8.valid_i = 1'b0;
    chk("wrap end busy",  32'(bus8.busy_o),  32'd0);
    chk("wrap end ready", 32'(bus8.ready_o), 32'd1);
    tick();
    chk("wrap drain valid", 32'(bus8.valid_o), 32'd0);

    // Backpressure after the first beat
    start_scan8(3'd6);
    tick();
    chk_beat8("bp beat0", 6, 1'b0);
    bus8.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat8("bp hold", 6, 1'b0);
    end
    bus8.ready_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_beat8("bp beat", (6 + i) % 8, (i == 7));
    end
    chk("bp end busy", 32'(bus8.busy_o), 32'd0);
    tick();
    chk("bp drain valid", 32'(bus8.valid_o), 32'd0);

    // Abort after the third beat, then a direct request
    start_scan8(3'd6);
    tick(); tick(); tick();
    chk_beat8("abort beat3", 0, 1'b0);
    bus8.abort_i = 1'b1;
    tick();
    bus8.abort_i = 1'b0;
    chk("abort valid", 32'(bus8.valid_o), 32'd0);
    chk("abort busy",  32'(bus8.busy_o),  32'd0);
    tick();
    chk("abort no beat", 32'(bus8.valid_o), 32'd0);
    bus8.valid_i = 1'b1; bus8.mode_i = 1'b0; bus8.sel_i = 3'd5;
    #1;
    chk("abort ready", 32'(bus8.ready_o), 32'd1);
    tick();
    bus8.valid_i = 1'b0;
    chk_beat8("abort direct", 5, 1'b1);
    tick();

    // Reset mid-scan with a stalled beat
    start_scan8(3'd6);
    tick();
    bus8.ready_i = 1'b0;
    tick();
    chk("rstmid busy", 32'(bus8.busy_o), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rstmid valid", 32'(bus8.valid_o), 32'd0);
    chk("rstmid out",   32'(bus8.out_o),   32'd0);
    chk("rstmid ch",    32'(bus8.ch_o),    32'd0);
    chk("rstmid last",  32'(bus8.last_o),  32'd0);
    chk("rstmid busy0", 32'(bus8.busy_o),  32'd0);
    rst_n = 1'b1;
    bus8.ready_i = 1'b1;
    #1;
    chk("rstmid ready", 32'(bus8.ready_o), 32'd1);
    tick();
    chk("rstmid idle valid", 32'(bus8.valid_o), 32'd0);
    chk("rstmid idle busy",  32'(bus8.busy_o),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
